// File: rtl/truth_table_bist.sv
// truth_table_bist: exhaustive self-test sweep of a small combinational block.
// The controller drives every input vector in ascending order and holds each
// one for SETTLE extra cycles. On the last cycle of each hold it compares the
// single-bit response against a built-in truth table.
//
//  state | meaning
//  IDLE  | waiting for start; stim parked at 0, results held
//  RUN   | sweeping vectors, counting settle cycles and comparing
//  DONE  | one-cycle done pulse; pass reflects the finished run
module truth_table_bist #(
  parameter int                  N_IN     = 4,
  parameter logic [2**N_IN-1:0]  EXPECTED = 16'hFA02,
  parameter int                  SETTLE   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            resp,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);

  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [7:0]      cnt;
  logic            mismatch;

  // The response is compared against the table entry of the vector on stim.
  assign mismatch = resp ^ EXPECTED[idx];

  // Sequencer: the state, the sweep counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      cnt              <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          stim <= '0;
          busy <= 1'b0;
          if (start) begin
            state            <= RUN;
            idx              <= '0;
            cnt              <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != SETTLE_C) begin
            cnt <= cnt + 8'd1;
          end else begin
            if (mismatch) begin
              fail_count <= fail_count + CNT_ONE;
              if (!first_fail_valid) begin
                first_fail_idx   <= idx;
                first_fail_valid <= 1'b1;
              end
            end
            if (idx == LAST_IDX) begin
              // pass must include the compare made on this same edge.
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              stim  <= '0;
              pass  <= (fail_count == '0) && !mismatch;
            end else begin
              idx  <= idx + IDX_ONE;
              stim <= idx + IDX_ONE;
              cnt  <= '0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_bist.sv
// Bench for truth_table_bist: two instances (SETTLE=1 and SETTLE=0) each drive
// a table-driven stand-in for the function block. Every run is predicted from
// the boolean formula of basic_Circuit and from the window arithmetic.
module tb_truth_table_bist;

  logic clk = 1'b0;
  logic rst;
  logic start1, start0;
  logic resp1, resp0;
  logic [3:0] stim1, stim0;
  logic busy1, busy0, done1, done0, pass1, pass0, ffv1, ffv0;
  logic [4:0] fc1, fc0;
  logic [3:0] ffi1, ffi0;

  logic [15:0] tbl1, tbl0, gold;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_bist #(.N_IN(4), .EXPECTED(16'hFA02), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .resp(resp1), .stim(stim1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_idx(ffi1), .first_fail_valid(ffv1));

  truth_table_bist #(.N_IN(4), .EXPECTED(16'hFA02), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start0), .resp(resp0), .stim(stim0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
    .first_fail_idx(ffi0), .first_fail_valid(ffv0));

  assign resp1 = tbl1[stim1];
  assign resp0 = tbl0[stim0];

  // View of whichever instance the current run uses.
  bit sel;
  logic [3:0] m_stim, m_ffi;
  logic [4:0] m_fc;
  logic m_busy, m_done, m_pass, m_ffv;
  always_comb begin
    m_stim = sel ? stim0 : stim1;
    m_ffi  = sel ? ffi0  : ffi1;
    m_fc   = sel ? fc0   : fc1;
    m_busy = sel ? busy0 : busy1;
    m_done = sel ? done0 : done1;
    m_pass = sel ? pass0 : pass1;
    m_ffv  = sel ? ffv0  : ffv1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit golden_f(input int v);
    bit a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return (a | ~b) & (b | d) & (a | ~c | ~d);
  endfunction

  task automatic set_start(input bit s, input bit v);
    if (s) start0 = v; else start1 = v;
  endtask

  // One complete run on instance s with a response table; optionally pulses
  // start while vector 6 is on stim, which must change nothing.
  task automatic run(input bit s, input logic [15:0] tbl, input bit poke6);
    int win, total, exp_fc, exp_ffi;
    bit exp_ffv;
    sel = s;
    if (s) tbl0 = tbl; else tbl1 = tbl;
    win = s ? 1 : 2;
    total = 16 * win;
    exp_fc = 0; exp_ffi = 0; exp_ffv = 0;
    for (int k = 0; k < 16; k++) begin
      if (tbl[k] != gold[k]) begin
        exp_fc++;
        if (!exp_ffv) begin exp_ffv = 1; exp_ffi = k; end
      end
    end
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    chk("e0_busy", m_busy, 1);
    chk("e0_fc_clr", m_fc, 0);
    chk("e0_ffv_clr", m_ffv, 0);
    chk("e0_pass_clr", m_pass, 0);
    chk("e0_stim", m_stim, 0);
    for (int j = 1; j <= total; j++) begin
      @(posedge clk); #1;
      set_start(s, 1'b0);
      if (j < total) begin
        chk("run_stim", m_stim, j / win);
        chk("run_busy_done", {m_busy, m_done}, 2'b10);
        if (poke6 && (j % win == 0) && (j / win == 6)) set_start(s, 1'b1);
      end else begin
        chk("end_done", m_done, 1);
        chk("end_busy", m_busy, 0);
        chk("end_stim", m_stim, 0);
        chk("end_pass", m_pass, exp_fc == 0);
        chk("end_fc", m_fc, exp_fc);
        chk("end_ffv", m_ffv, exp_ffv);
        if (exp_ffv) chk("end_ffi", m_ffi, exp_ffi);
      end
    end
    @(posedge clk); #1;
    chk("post_done", m_done, 0);
    chk("post_hold_fc", m_fc, exp_fc);
    chk("post_hold_pass", m_pass, exp_fc == 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", m_busy, 0);
  endtask

  initial begin
    bit seen5, bad;
    for (int k = 0; k < 16; k++) gold[k] = golden_f(k);
    tbl1 = gold; tbl0 = gold;
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s1_outs", {stim1, busy1, done1, pass1, fc1, ffi1, ffv1}, 0);
    chk("rst_s0_outs", {stim0, busy0, done0, pass0, fc0, ffi0, ffv0}, 0);
    @(negedge clk);
    rst = 1'b0;

    run(0, gold, 0);
    run(0, 16'h0000, 0);
    run(0, 16'hFFFF, 1);
    run(0, gold, 0);
    for (int r = 0; r < 4; r++) run(r[0], 16'($urandom), $urandom_range(0, 1) == 1);

    // Abort mid-run with rst while vector 5 is on stim.
    sel = 0; tbl1 = gold; seen5 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int j = 0; j < 40 && !seen5; j++) begin
      @(posedge clk); #1;
      if (stim1 == 4'd5) seen5 = 1;
    end
    chk("abort_reach5", seen5, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_async_outs", {stim1, busy1, done1, pass1, fc1, ffi1, ffv1}, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (done1 || busy1) bad = 1;
    end
    chk("abort_no_done_or_restart", bad, 0);

    run(1, gold, 0);
    run(1, 16'($urandom), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
